// File: rtl/sap_pkg.sv
// sap_pkg: shared constants and types for the SAP-1 controller-sequencer.
//   Opcodes:      OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT (4-bit IR upper nibble)
//   T-states:     T1..T6 one-hot ring constants, bit0 = T1
//   Control word: 12-bit packed word, MSB first in the controller's port order,
//                 with CW_* bit indices for code that works on the flat vector
package sap_pkg;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam int T_W = 6;

    localparam logic [T_W-1:0] T1 = 6'b000001;
    localparam logic [T_W-1:0] T2 = 6'b000010;
    localparam logic [T_W-1:0] T3 = 6'b000100;
    localparam logic [T_W-1:0] T4 = 6'b001000;
    localparam logic [T_W-1:0] T5 = 6'b010000;
    localparam logic [T_W-1:0] T6 = 6'b100000;

    localparam int CW_W          = 12;
    localparam int CW_PC_INC     = 11;
    localparam int CW_PC_OUT_EN  = 10;
    localparam int CW_MAR_LOAD   = 9;
    localparam int CW_RAM_OUT_EN = 8;
    localparam int CW_IR_LOAD    = 7;
    localparam int CW_IR_OUT_EN  = 6;
    localparam int CW_A_LOAD     = 5;
    localparam int CW_A_OUT_EN   = 4;
    localparam int CW_ALU_SUB    = 3;
    localparam int CW_ALU_OUT_EN = 2;
    localparam int CW_B_LOAD     = 1;
    localparam int CW_OUT_LOAD   = 0;

    // Field order matches the CW_* indices above (first field = MSB).
    typedef struct packed {
        logic pc_inc;
        logic pc_out_en;
        logic mar_load;
        logic ram_out_en;
        logic ir_load;
        logic ir_out_en;
        logic a_load;
        logic a_out_en;
        logic alu_sub;
        logic alu_out_en;
        logic b_load;
        logic out_load;
    } ctrl_word_t;

    function automatic logic is_onehot(input logic [T_W-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/sap_ring_counter.sv
// sap_ring_counter: 6-state one-hot T-state ring for the SAP-1 controller.
//   clk     rising-edge clock
//   clr     synchronous active-high reset, forces T1
//   hold    freeze the ring (halted machine)
//   restart return to T1 on this edge (early end of instruction)
//   t_state one-hot ring state, bit0 = T1
module sap_ring_counter
    import sap_pkg::*;
(
    input  logic           clk,
    input  logic           clr,
    input  logic           hold,
    input  logic           restart,
    output logic [T_W-1:0] t_state
);

    // A corrupted (non-one-hot) ring recovers to T1 even while held, so a
    // glitch cannot leave the machine frozen in an undefined state.
    always_ff @(posedge clk) begin
        if (clr)
            t_state <= T1;
        else if (!is_onehot(t_state))
            t_state <= T1;
        else if (hold)
            t_state <= t_state;
        else if (restart)
            t_state <= T1;
        else
            t_state <= {t_state[T_W-2:0], t_state[T_W-1]};
    end

endmodule

// File: rtl/sap_controller.sv
// sap_controller: SAP-1 controller-sequencer; ring counter plus Moore opcode decoder.
//   clk, clr      clock and synchronous active-high reset
//   opcode        IR upper nibble, stable from T4 to end of instruction
//   pc_inc .. out_load  bus/load strobes, pure function of t_state and opcode
//   halt          machine halted, gates the datapath clock enable
//   t_state       one-hot ring state, bit0 = T1
// Build option: define SAP_CTRL_EARLY_FETCH_EN to end each instruction after its
// last non-empty execute state instead of always running all six T-states.
module sap_controller
    import sap_pkg::*;
#(
    parameter int OPCODE_W        = 4,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [OPCODE_W-1:0] opcode,
    output logic                pc_inc,
    output logic                pc_out_en,
    output logic                mar_load,
    output logic                ram_out_en,
    output logic                ir_load,
    output logic                ir_out_en,
    output logic                a_load,
    output logic                a_out_en,
    output logic                alu_sub,
    output logic                alu_out_en,
    output logic                b_load,
    output logic                out_load,
    output logic                halt,
    output logic [T_W-1:0]      t_state
);

    logic       halt_flag;
    logic       restart;
    logic       is_lda, is_add, is_sub, is_out, is_hlt, illegal, halt_op;
    ctrl_word_t cw;

    assign is_lda  = opcode == OPCODE_W'(OP_LDA);
    assign is_add  = opcode == OPCODE_W'(OP_ADD);
    assign is_sub  = opcode == OPCODE_W'(OP_SUB);
    assign is_out  = opcode == OPCODE_W'(OP_OUT);
    assign is_hlt  = opcode == OPCODE_W'(OP_HLT);
    assign illegal = !(is_lda || is_add || is_sub || is_out || is_hlt);
    assign halt_op = is_hlt || (HALT_ON_ILLEGAL && illegal);

    // Halt is visible combinationally in T4 so the ring holds on that same edge.
    assign halt = !clr && (halt_flag || (t_state == T4 && halt_op));

    always_ff @(posedge clk) begin
        if (clr)
            halt_flag <= 1'b0;
        else if (halt)
            halt_flag <= 1'b1;
    end

`ifdef SAP_CTRL_EARLY_FETCH_EN
    assign restart = (t_state == T5 && is_lda) ||
                     (t_state == T4 && is_out) ||
                     (t_state == T3 && !HALT_ON_ILLEGAL && illegal);
`else
    assign restart = 1'b0;
`endif

    sap_ring_counter u_ring (
        .clk     (clk),
        .clr     (clr),
        .hold    (halt),
        .restart (restart),
        .t_state (t_state)
    );

    always_comb begin
        cw = '0;
        if (!clr && !halt_flag) begin
            case (t_state)
                T1: begin
                    cw.pc_out_en = 1'b1;
                    cw.mar_load  = 1'b1;
                end
                T2: cw.pc_inc = 1'b1;
                T3: begin
                    cw.ram_out_en = 1'b1;
                    cw.ir_load    = 1'b1;
                end
                T4: begin
                    cw.ir_out_en = is_lda || is_add || is_sub;
                    cw.mar_load  = is_lda || is_add || is_sub;
                    cw.a_out_en  = is_out;
                    cw.out_load  = is_out;
                end
                T5: begin
                    cw.ram_out_en = is_lda || is_add || is_sub;
                    cw.a_load     = is_lda;
                    cw.b_load     = is_add || is_sub;
                    cw.alu_sub    = is_sub;
                end
                T6: begin
                    cw.alu_out_en = is_add || is_sub;
                    cw.a_load     = is_add || is_sub;
                    cw.alu_sub    = is_sub;
                end
                default: cw = '0;
            endcase
        end
    end

    assign {pc_inc, pc_out_en, mar_load, ram_out_en, ir_load, ir_out_en,
            a_load, a_out_en, alu_sub, alu_out_en, b_load, out_load} = cw;

endmodule

// File: tb/tb_sap_controller.sv
// tb_sap_controller: scoreboard bench for sap_controller with hand-written control words.
module tb_sap_controller;

    // Control words, bit order: pc_inc pc_out_en mar_load ram_out_en ir_load ir_out_en
    //                          a_load a_out_en alu_sub alu_out_en b_load out_load
    localparam logic [11:0] NONE    = 12'b0000_0000_0000;
    localparam logic [11:0] F_T1    = 12'b0110_0000_0000;
    localparam logic [11:0] F_T2    = 12'b1000_0000_0000;
    localparam logic [11:0] F_T3    = 12'b0001_1000_0000;
    localparam logic [11:0] MEM_T4  = 12'b0010_0100_0000;
    localparam logic [11:0] LDA_T5  = 12'b0001_0010_0000;
    localparam logic [11:0] ADD_T5  = 12'b0001_0000_0010;
    localparam logic [11:0] SUB_T5  = 12'b0001_0000_1010;
    localparam logic [11:0] ADD_T6  = 12'b0000_0010_0100;
    localparam logic [11:0] SUB_T6  = 12'b0000_0010_1100;
    localparam logic [11:0] OUT_T4  = 12'b0000_0001_0001;

`ifdef SAP_CTRL_EARLY_FETCH_EN
    localparam int LDA_LEN = 5;
    localparam int OUT_LEN = 4;
`else
    localparam int LDA_LEN = 6;
    localparam int OUT_LEN = 6;
`endif

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [3:0] opcode = 4'h0;
    logic       pc_inc, pc_out_en, mar_load, ram_out_en, ir_load, ir_out_en;
    logic       a_load, a_out_en, alu_sub, alu_out_en, b_load, out_load, halt;
    logic [5:0] t_state;

    typedef struct {
        logic [5:0]  t;
        logic        h;
        logic [11:0] cw;
        string       name;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    sap_controller dut (
        .clk        (clk),
        .clr        (clr),
        .opcode     (opcode),
        .pc_inc     (pc_inc),
        .pc_out_en  (pc_out_en),
        .mar_load   (mar_load),
        .ram_out_en (ram_out_en),
        .ir_load    (ir_load),
        .ir_out_en  (ir_out_en),
        .a_load     (a_load),
        .a_out_en   (a_out_en),
        .alu_sub    (alu_sub),
        .alu_out_en (alu_out_en),
        .b_load     (b_load),
        .out_load   (out_load),
        .halt       (halt),
        .t_state    (t_state)
    );

    // Monitor: one output set per cycle, compared mid-cycle against the queue.
    initial begin
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                exp_t e;
                logic [11:0] cw;
                int drivers;
                e  = q.pop_front();
                cw = {pc_inc, pc_out_en, mar_load, ram_out_en, ir_load, ir_out_en,
                      a_load, a_out_en, alu_sub, alu_out_en, b_load, out_load};
                drivers = int'(pc_out_en) + int'(ram_out_en) + int'(ir_out_en)
                        + int'(a_out_en) + int'(alu_out_en);
                n_cmp++;
                if (t_state !== e.t || halt !== e.h || cw !== e.cw) begin
                    n_bad++;
                    $display("FAIL %s: got t=%b halt=%b cw=%b, want t=%b halt=%b cw=%b",
                             e.name, t_state, halt, cw, e.t, e.h, e.cw);
                end
                n_cmp++;
                if (drivers > 1) begin
                    n_bad++;
                    $display("FAIL %s bus: %0d drivers high, want at most 1", e.name, drivers);
                end
            end
        end
    end

    // Drive inputs for the current cycle and record what the outputs must be.
    task automatic step(input logic c, input logic [3:0] op, input logic [5:0] t,
                        input logic h, input logic [11:0] cw, input string name);
        exp_t e;
        clr    = c;
        opcode = op;
        e.t = t; e.h = h; e.cw = cw; e.name = name;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [3:0] op, input logic [11:0] c4,
                             input logic [11:0] c5, input logic [11:0] c6,
                             input int len, input string name);
        for (int i = 0; i < len; i++) begin
            logic [11:0] cw;
            cw = i == 0 ? F_T1 : i == 1 ? F_T2 : i == 2 ? F_T3 :
                 i == 3 ? c4   : i == 4 ? c5   : c6;
            step(1'b0, op, 6'b1 << i, 1'b0, cw, $sformatf("%s_t%0d", name, i + 1));
        end
    endtask

    task automatic fetch(input logic [3:0] op, input string name);
        step(1'b0, op, 6'b000001, 1'b0, F_T1, {name, "_t1"});
        step(1'b0, op, 6'b000010, 1'b0, F_T2, {name, "_t2"});
        step(1'b0, op, 6'b000100, 1'b0, F_T3, {name, "_t3"});
    endtask

    initial begin
        @(posedge clk);
        #1;
        step(1'b1, 4'h0, 6'b000001, 1'b0, NONE, "reset_hold");
        step(1'b1, 4'h0, 6'b000001, 1'b0, NONE, "reset_hold2");
        run_instr(4'h0, MEM_T4, LDA_T5, NONE,   LDA_LEN, "lda");
        run_instr(4'h1, MEM_T4, ADD_T5, ADD_T6, 6,       "add");
        run_instr(4'h2, MEM_T4, SUB_T5, SUB_T6, 6,       "sub");
        run_instr(4'hE, OUT_T4, NONE,   NONE,   OUT_LEN, "out");
        fetch(4'hF, "hlt");
        for (int i = 0; i < 21; i++)
            step(1'b0, 4'hF, 6'b001000, 1'b1, NONE, $sformatf("hlt_frozen%0d", i));
        step(1'b1, 4'hF, 6'b001000, 1'b0, NONE, "hlt_clr");
        fetch(4'h1, "add_abort");
        step(1'b0, 4'h1, 6'b001000, 1'b0, MEM_T4, "add_abort_t4");
        step(1'b1, 4'h1, 6'b010000, 1'b0, NONE, "add_abort_clr_t5");
        run_instr(4'h1, MEM_T4, ADD_T5, ADD_T6, 6, "add_after_clr");
        fetch(4'h7, "ill");
        for (int i = 0; i < 4; i++)
            step(1'b0, 4'h7, 6'b001000, 1'b1, NONE, $sformatf("ill_halt%0d", i));
        step(1'b1, 4'h7, 6'b001000, 1'b0, NONE, "ill_clr");
        run_instr(4'h0, MEM_T4, LDA_T5, NONE, LDA_LEN, "lda_final");
        for (int i = 0; i < 10 && q.size() > 0; i++)
            @(negedge clk);
        if (q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected entries never compared, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "timeout");
    end

endmodule
